// File: rtl/finalproject_trivia_onchip_ram_dp_pkg.sv
// Shared constants for the dual-port on-chip RAM: legal read latencies and default geometry.
// Latency: n/a (package only).
// Backpressure: n/a.
package finalproject_trivia_onchip_ram_dp_pkg;

    localparam int RL_MIN = 1;   // registered array read only
    localparam int RL_MAX = 2;   // plus an output register

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DEPTH      = 25000;

endpackage

// File: rtl/finalproject_trivia_ram_rdpipe.sv
// Read-return pipeline for one RAM port: turns an accepted read into readdata/readdatavalid.
// Latency: READ_LATENCY enabled cycles from issue (raw data already registered by the array).
// Backpressure: none; the whole pipe freezes while en_i is low.
module finalproject_trivia_ram_rdpipe
    import finalproject_trivia_onchip_ram_dp_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = RL_MIN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  issue_i,
    input  logic [DATA_WIDTH-1:0] raw_dat_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);

    logic                  vld1_q;
    logic                  seen_q;
    logic [DATA_WIDTH-1:0] stage1_dat;

    // Stage-1 valid tracks the array read register; seen_q masks the un-reset array register to zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld1_q <= 1'b0;
            seen_q <= 1'b0;
        end else if (en_i) begin
            vld1_q <= issue_i;
            if (issue_i) begin
                seen_q <= 1'b1;
            end
        end
    end

    assign stage1_dat = seen_q ? raw_dat_i : '0;

    generate
        if (READ_LATENCY == RL_MAX) begin : g_oreg
            logic                  vld2_q;
            logic [DATA_WIDTH-1:0] dat2_q;

            // Output register: data and valid move together so they can never skew.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld2_q <= 1'b0;
                    dat2_q <= '0;
                end else if (en_i) begin
                    vld2_q <= vld1_q;
                    dat2_q <= stage1_dat;
                end
            end

            assign rdata_o  = dat2_q;
            assign rvalid_o = vld2_q;
        end else begin : g_direct
            assign rdata_o  = stage1_dat;
            assign rvalid_o = vld1_q;
        end
    endgenerate

endmodule

// File: rtl/finalproject_trivia_onchip_ram_dp.sv
// True dual-port byte-enabled RAM with Avalon-MM style ports, read-old-data and s1-wins write arbitration.
// Latency: reads return READ_LATENCY (1 or 2) enabled cycles after acceptance; writes land at the edge.
// Backpressure: none (no waitrequest); clken low or reset_req high freezes the entire block.
module finalproject_trivia_onchip_ram_dp
    import finalproject_trivia_onchip_ram_dp_pkg::*;
#(
    parameter int    DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int    DEPTH        = DEF_DEPTH,
    parameter int    READ_LATENCY = RL_MIN,
    parameter string INIT_FILE    = "finalproject_trivia_onchip_memory2_0.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    collision
);

    localparam int                  NB        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    generate
        if ((DATA_WIDTH % 8) != 0) begin : g_bad_dw
            $error("DATA_WIDTH must be a multiple of 8");
        end
        if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
            $error("DEPTH exceeds the address space");
        end
        if ((READ_LATENCY != RL_MIN) && (READ_LATENCY != RL_MAX)) begin : g_bad_rl
            $error("READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_raw_q;
    logic [DATA_WIDTH-1:0] rd2_raw_q;
    logic                  collision_q;

    logic en;
    logic in1, in2;
    logic wr1_go, wr2_go;
    logic rd1_go, rd2_go;

    assign en     = clken & ~reset_req;
    assign in1    = ({1'b0, s1_address} < DEPTH_LIM);
    assign in2    = ({1'b0, s2_address} < DEPTH_LIM);
    // A write that is also flagged as a read is a write only; out-of-range writes are dropped.
    assign wr1_go = en & s1_chipselect & s1_write & in1;
    assign wr2_go = en & s2_chipselect & s2_write & in2;
    assign rd1_go = en & s1_chipselect & s1_read & ~s1_write;
    assign rd2_go = en & s2_chipselect & s2_read & ~s2_write;

    // Storage: s2 lanes are written first so s1 overrides exactly the bytes it enables on a shared address;
    // reads sample with non-blocking semantics and therefore see the pre-write word.
    always_ff @(posedge clk) begin
        if (wr2_go) begin
            for (int b = 0; b < NB; b++) begin
                if (s2_byteenable[b]) begin
                    mem_q[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
                end
            end
        end
        if (wr1_go) begin
            for (int b = 0; b < NB; b++) begin
                if (s1_byteenable[b]) begin
                    mem_q[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
                end
            end
        end
        if (rd1_go) begin
            rd1_raw_q <= in1 ? mem_q[s1_address] : '0;
        end
        if (rd2_go) begin
            rd2_raw_q <= in2 ? mem_q[s2_address] : '0;
        end
    end

    // Sticky flag for a same-word write from both ports; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_q <= 1'b0;
        end else if (wr1_go && wr2_go && (s1_address == s2_address)) begin
            collision_q <= 1'b1;
        end
    end

    assign collision = collision_q;

    finalproject_trivia_ram_rdpipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rdpipe1 (
        .clk      (clk),
        .reset    (reset),
        .en_i     (en),
        .issue_i  (rd1_go),
        .raw_dat_i(rd1_raw_q),
        .rdata_o  (s1_readdata),
        .rvalid_o (s1_readdatavalid)
    );

    finalproject_trivia_ram_rdpipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rdpipe2 (
        .clk      (clk),
        .reset    (reset),
        .en_i     (en),
        .issue_i  (rd2_go),
        .raw_dat_i(rd2_raw_q),
        .rdata_o  (s2_readdata),
        .rvalid_o (s2_readdatavalid)
    );

endmodule

// File: tb/tb_finalproject_trivia_onchip_ram_dp.sv
// Bench for the dual-port RAM: one instance at read latency 1 and one at 2, sharing all inputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_finalproject_trivia_onchip_ram_dp;

    localparam int DW    = 32;
    localparam int AW    = 15;
    localparam int DEPTH = 25000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clken, reset_req;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write;
    logic          s2_chipselect, s2_read, s2_write;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata;

    logic [DW-1:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
    logic          a_s1_v, a_s2_v, b_s1_v, b_s2_v;
    logic          a_col, b_col;

    finalproject_trivia_onchip_ram_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_FILE("")
    ) u_dut_l1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_v),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_v),
        .collision(a_col)
    );

    finalproject_trivia_onchip_ram_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .INIT_FILE("")
    ) u_dut_l2 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_v),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_v),
        .collision(b_col)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          vld;
        bit          known;
        logic [31:0] dat;
    } rd_rec_t;

    logic [31:0] mem_m [int];
    rd_rec_t     h1[$];     // one record per enabled cycle, port 1
    rd_rec_t     h2[$];     // one record per enabled cycle, port 2
    bit          col_m;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rd_rec_t pick(input rd_rec_t q[$], input int l);
        rd_rec_t r;
        r.vld = 1'b0; r.known = 1'b0; r.dat = '0;
        if (q.size() >= l) r = q[q.size() - l];
        return r;
    endfunction

    function automatic rd_rec_t model_read(input bit go, input int a);
        rd_rec_t r;
        r.vld = go; r.known = 1'b1; r.dat = '0;
        if (a < DEPTH) begin
            r.known = mem_m.exists(a);
            if (r.known) r.dat = mem_m[a];
        end
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Apply the architectural effect of the upcoming edge using the current inputs.
    task automatic model_edge();
        int a1, a2;
        bit w1, w2;
        logic [31:0] word;
        a1 = int'(s1_address);
        a2 = int'(s2_address);
        if (!(clken && !reset_req)) return;
        h1.push_back(model_read(s1_chipselect && s1_read && !s1_write, a1));
        h2.push_back(model_read(s2_chipselect && s2_read && !s2_write, a2));
        while (h1.size() > 4) void'(h1.pop_front());
        while (h2.size() > 4) void'(h2.pop_front());
        w1 = s1_chipselect && s1_write && (a1 < DEPTH);
        w2 = s2_chipselect && s2_write && (a2 < DEPTH);
        if (w1 && w2 && a1 == a2) begin
            col_m = 1'b1;
            word = mem_m.exists(a1) ? mem_m[a1] : 32'h0;
            word = merge(word, s2_writedata, s2_byteenable);   // s2 lands everywhere it enables...
            word = merge(word, s1_writedata, s1_byteenable);   // ...then s1 owns its own bytes
            mem_m[a1] = word;
        end else begin
            if (w1) mem_m[a1] = merge(mem_m.exists(a1) ? mem_m[a1] : 32'h0, s1_writedata, s1_byteenable);
            if (w2) mem_m[a2] = merge(mem_m.exists(a2) ? mem_m[a2] : 32'h0, s2_writedata, s2_byteenable);
        end
    endtask

    task automatic chk_port(input string tag, input logic v, input logic [31:0] d, input rd_rec_t e);
        chk({tag, "_vld"}, {31'b0, v}, {31'b0, e.vld});
        if (e.vld && e.known) chk({tag, "_dat"}, d, e.dat);
    endtask

    task automatic check_all();
        chk_port("l1_s1", a_s1_v, a_s1_rd, pick(h1, 1));
        chk_port("l1_s2", a_s2_v, a_s2_rd, pick(h2, 1));
        chk_port("l2_s1", b_s1_v, b_s1_rd, pick(h1, 2));
        chk_port("l2_s2", b_s2_v, b_s2_rd, pick(h2, 2));
        chk("l1_collision", {31'b0, a_col}, {31'b0, col_m});
        chk("l2_collision", {31'b0, b_col}, {31'b0, col_m});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        h1.delete(); h2.delete(); col_m = 1'b0;
        #1;
        chk("rst_l1_s1_dat", a_s1_rd, 32'h0);
        chk("rst_l2_s2_dat", b_s2_rd, 32'h0);
        chk("rst_valids", {28'b0, a_s1_v, a_s2_v, b_s1_v, b_s2_v}, 32'h0);
        chk("rst_collision", {30'b0, a_col, b_col}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // op: 0 idle, 1 read, 2 write, 3 read+write
    task automatic set_p1(input logic [1:0] op, input int a, input logic [3:0] be, input logic [31:0] wd);
        s1_chipselect = (op != 2'd0); s1_read = op[0]; s1_write = op[1];
        s1_address = AW'(a); s1_byteenable = be; s1_writedata = wd;
    endtask

    task automatic set_p2(input logic [1:0] op, input int a, input logic [3:0] be, input logic [31:0] wd);
        s2_chipselect = (op != 2'd0); s2_read = op[0]; s2_write = op[1];
        s2_address = AW'(a); s2_byteenable = be; s2_writedata = wd;
    endtask

    function automatic int rand_addr();
        int r;
        r = int'($urandom_range(0, 18));
        if (r < 16) return r;
        if (r == 16) return DEPTH - 1;
        if (r == 17) return DEPTH;
        return 32767;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  op1; int a1; logic [3:0] be1; logic [31:0] wd1;
        logic [1:0]  op2; int a2; logic [3:0] be2; logic [31:0] wd2;
        logic        ev1; logic [31:0] ed1;
        logic        ev2; logic [31:0] ed2;
        logic        ecol;
    } vec_t;

    vec_t tbl[14];

    initial begin
        reset = 1'b0; clken = 1'b1; reset_req = 1'b0;
        set_p1(2'd0, 0, 4'h0, 32'h0);
        set_p2(2'd0, 0, 4'h0, 32'h0);
        col_m = 1'b0;

        tbl[0]  = '{2'd2, 16'h10, 4'hF, 32'hDEADBEEF, 2'd0, 0,     4'h0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[1]  = '{2'd0, 0,      4'h0, 32'h0,       2'd1, 16'h10, 4'h0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{2'd2, 5,      4'hF, 32'h11223344, 2'd0, 0,     4'h0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[3]  = '{2'd2, 5,      4'h5, 32'hAABBCCDD, 2'd0, 0,     4'h0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[4]  = '{2'd1, 5,      4'h0, 32'h0,       2'd0, 0,      4'h0, 32'h0,      1'b1, 32'h11BB33DD, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{2'd2, 7,      4'hC, 32'hFFFF0000, 2'd2, 7,     4'hF, 32'h0000FFFF, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1};
        tbl[6]  = '{2'd0, 0,      4'h0, 32'h0,       2'd1, 7,      4'h0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[7]  = '{2'd1, 25000,  4'h0, 32'h0,       2'd0, 0,      4'h0, 32'h0,      1'b1, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[8]  = '{2'd2, 0,      4'hF, 32'h12345678, 2'd0, 0,     4'h0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[9]  = '{2'd0, 0,      4'h0, 32'h0,       2'd2, 25000,  4'hF, 32'hCAFECAFE, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1};
        tbl[10] = '{2'd1, 0,      4'h0, 32'h0,       2'd0, 0,      4'h0, 32'h0,      1'b1, 32'h12345678, 1'b0, 32'h0,        1'b1};
        tbl[11] = '{2'd2, 16'h10, 4'hF, 32'h0,       2'd1, 16'h10, 4'h0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1};
        tbl[12] = '{2'd3, 16'h20, 4'hF, 32'h00000055, 2'd0, 0,     4'h0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[13] = '{2'd0, 0,      4'h0, 32'h0,       2'd1, 16'h20, 4'h0, 32'h0,      1'b0, 32'h0,        1'b1, 32'h00000055, 1'b1};

        do_reset();

        // Table vectors, compared directly on the latency-1 instance.
        for (int i = 0; i < 14; i++) begin
            set_p1(tbl[i].op1, tbl[i].a1, tbl[i].be1, tbl[i].wd1);
            set_p2(tbl[i].op2, tbl[i].a2, tbl[i].be2, tbl[i].wd2);
            step();
            chk($sformatf("tbl%0d_s1_vld", i), {31'b0, a_s1_v}, {31'b0, tbl[i].ev1});
            if (tbl[i].ev1) chk($sformatf("tbl%0d_s1_dat", i), a_s1_rd, tbl[i].ed1);
            chk($sformatf("tbl%0d_s2_vld", i), {31'b0, a_s2_v}, {31'b0, tbl[i].ev2});
            if (tbl[i].ev2) chk($sformatf("tbl%0d_s2_dat", i), a_s2_rd, tbl[i].ed2);
            chk($sformatf("tbl%0d_collision", i), {31'b0, a_col}, {31'b0, tbl[i].ecol});
        end
        set_p1(2'd0, 0, 4'h0, 32'h0);
        set_p2(2'd0, 0, 4'h0, 32'h0);
        step();
        chk("collision_sticky", {31'b0, a_col}, 32'h1);

        // Latency-2 streaming: four back-to-back reads of @0..3.
        for (int i = 0; i < 4; i++) begin
            set_p1(2'd2, i, 4'hF, 32'hA0000000 + 32'(i));
            step();
        end
        for (int j = 0; j < 6; j++) begin
            if (j < 4) set_p1(2'd1, j, 4'h0, 32'h0);
            else       set_p1(2'd0, 0, 4'h0, 32'h0);
            step();
            chk($sformatf("l2_stream%0d_vld", j), {31'b0, b_s1_v}, (j >= 1 && j <= 4) ? 32'h1 : 32'h0);
            if (j >= 1 && j <= 4) chk($sformatf("l2_stream%0d_dat", j), b_s1_rd, 32'hA0000000 + 32'(j - 1));
        end

        // Read then a 3-cycle clken stall: latency-2 valid must wait for the stall to end.
        set_p1(2'd1, 1, 4'h0, 32'h0);
        step();
        set_p1(2'd0, 0, 4'h0, 32'h0);
        clken = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("stall%0d_l2_vld", j), {31'b0, b_s1_v}, 32'h0);
        end
        clken = 1'b1;
        step();
        chk("stall_release_vld", {31'b0, b_s1_v}, 32'h1);
        chk("stall_release_dat", b_s1_rd, 32'hA0000001);

        // Collision, then a read caught by a reset pulse during a stall: nothing comes out afterwards.
        set_p1(2'd2, 9, 4'hF, 32'h1);
        set_p2(2'd2, 9, 4'hF, 32'h2);
        step();
        set_p2(2'd0, 0, 4'h0, 32'h0);
        set_p1(2'd1, 2, 4'h0, 32'h0);
        step();
        set_p1(2'd0, 0, 4'h0, 32'h0);
        clken = 1'b0;
        step();
        do_reset();
        clken = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("post_rst%0d_vlds", j), {30'b0, a_s1_v, b_s1_v}, 32'h0);
            chk($sformatf("post_rst%0d_col", j), {30'b0, a_col, b_col}, 32'h0);
        end
        set_p1(2'd1, 9, 4'h0, 32'h0);
        step();
        chk("mem_survives_reset", a_s1_rd, 32'h00000001);

        // Randomized traffic against the model; first give every address in the pool a known value.
        for (int i = 0; i < 17; i++) begin
            set_p1(2'd2, (i < 16) ? i : DEPTH - 1, 4'hF, $urandom);
            set_p2(2'd0, 0, 4'h0, 32'h0);
            step();
        end
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            clken     = ($urandom_range(0, 7) != 0);
            reset_req = ($urandom_range(0, 15) == 0);
            set_p1(2'($urandom_range(0, 3)), rand_addr(), 4'($urandom), $urandom);
            set_p2(2'($urandom_range(0, 3)), rand_addr(), 4'($urandom), $urandom);
            if ($urandom_range(0, 5) == 0) s2_address = s1_address;
            if ($urandom_range(0, 9) == 0) s1_chipselect = 1'b0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
